// File: rtl/mem_access_unit.sv
// Memory-side stage behind the multi-cycle controller: turns single-cycle memory strobes
// into a req/ack handshake and holds the Instruction, OldPC and Data registers.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_AdrSrc,
  input  logic [ADDR_W-1:0] i_PC,
  input  logic [ADDR_W-1:0] i_Result,
  input  logic [DATA_W-1:0] i_WriteData,
  input  logic              i_IRWrite,
  input  logic              i_MemWrite,
  input  logic              i_MemRead,
  output logic              o_MemReq,
  output logic              o_MemWe,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [DATA_W-1:0] o_MemWData,
  input  logic              i_MemAck,
  input  logic [DATA_W-1:0] i_MemRData,
  output logic [DATA_W-1:0] o_Instr,
  output logic [ADDR_W-1:0] o_OldPC,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Stall,
  output logic              o_Fault
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] KIND_FETCH = 2'd0;
  localparam logic [1:0] KIND_STORE = 2'd1;
  localparam logic [1:0] KIND_LOAD  = 2'd2;

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        kind;
  logic [1:0]        next_kind;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] pending_pc;
  logic [ADDR_W-1:0] addr_sel;
  logic              any_strobe;

  always_comb begin
    any_strobe = i_IRWrite | i_MemWrite | i_MemRead;
    addr_sel   = i_AdrSrc ? i_Result : i_PC;
    next_kind  = KIND_LOAD;
    if (i_IRWrite)
      next_kind = KIND_FETCH;
    else if (i_MemWrite)
      next_kind = KIND_STORE;
    o_Stall = ((state == ST_IDLE) && any_strobe) || (state == ST_WAIT);
  end

  // An ack landing on the last wait cycle still completes the access normally.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      kind       <= KIND_FETCH;
      wait_cnt   <= '0;
      pending_pc <= '0;
      o_MemReq   <= 1'b0;
      o_MemWe    <= 1'b0;
      o_MemAddr  <= '0;
      o_MemWData <= '0;
      o_Instr    <= '0;
      o_OldPC    <= '0;
      o_Data     <= '0;
      o_Fault    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_strobe) begin
            o_MemAddr  <= addr_sel;
            o_MemWData <= i_WriteData;
            kind       <= next_kind;
            wait_cnt   <= '0;
            if (i_IRWrite)
              pending_pc <= i_PC;
            if (addr_sel[1:0] != 2'b00) begin
              o_Fault <= 1'b1;
              state   <= ST_DONE;
            end else begin
              o_MemReq <= 1'b1;
              o_MemWe  <= (next_kind == KIND_STORE);
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_MemAck) begin
            case (kind)
              KIND_FETCH: begin
                o_Instr <= i_MemRData;
                o_OldPC <= pending_pc;
              end
              KIND_LOAD: o_Data <= i_MemRData;
              default: ;
            endcase
            o_MemReq <= 1'b0;
            o_MemWe  <= 1'b0;
            state    <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            o_Fault  <= 1'b1;
            o_MemReq <= 1'b0;
            o_MemWe  <= 1'b0;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, store, load, misalignment, timeout and reset cases
// with hand-computed expected values.
module tb_mem_access_unit;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_AdrSrc;
  logic [31:0] i_PC;
  logic [31:0] i_Result;
  logic [31:0] i_WriteData;
  logic        i_IRWrite;
  logic        i_MemWrite;
  logic        i_MemRead;
  logic        o_MemReq;
  logic        o_MemWe;
  logic [31:0] o_MemAddr;
  logic [31:0] o_MemWData;
  logic        i_MemAck;
  logic [31:0] i_MemRData;
  logic [31:0] o_Instr;
  logic [31:0] o_OldPC;
  logic [31:0] o_Data;
  logic        o_Stall;
  logic        o_Fault;

  int checks = 0;
  int passes = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_AdrSrc(i_AdrSrc), .i_PC(i_PC),
    .i_Result(i_Result), .i_WriteData(i_WriteData), .i_IRWrite(i_IRWrite),
    .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead), .o_MemReq(o_MemReq),
    .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData),
    .i_MemAck(i_MemAck), .i_MemRData(i_MemRData), .o_Instr(o_Instr),
    .o_OldPC(o_OldPC), .o_Data(o_Data), .o_Stall(o_Stall), .o_Fault(o_Fault)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    else
      passes++;
  endtask

  task automatic applyStimulus(input logic adr_src, input logic [31:0] pc, input logic [31:0] result,
                               input logic [31:0] wdata, input logic irw, input logic mw,
                               input logic mr);
    i_AdrSrc    = adr_src;
    i_PC        = pc;
    i_Result    = result;
    i_WriteData = wdata;
    i_IRWrite   = irw;
    i_MemWrite  = mw;
    i_MemRead   = mr;
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic doReset();
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
  endtask

  initial begin
    i_MemAck   = 1'b0;
    i_MemRData = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    i_Reset = 1'b1;
    step();
    step();
    i_Reset = 1'b0;
    #1;
    checkOutput("rst_req",   {31'd0, o_MemReq}, 32'd0);
    checkOutput("rst_we",    {31'd0, o_MemWe},  32'd0);
    checkOutput("rst_addr",  o_MemAddr,         32'd0);
    checkOutput("rst_instr", o_Instr,           32'd0);
    checkOutput("rst_data",  o_Data,            32'd0);
    checkOutput("rst_fault", {31'd0, o_Fault},  32'd0);
    checkOutput("rst_stall", {31'd0, o_Stall},  32'd0);

    // Fetch at PC 0x10, ack in the second WAIT cycle
    applyStimulus(1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("f_stall0", {31'd0, o_Stall}, 32'd1);
    step();
    checkOutput("f_req1",   {31'd0, o_MemReq}, 32'd1);
    checkOutput("f_we1",    {31'd0, o_MemWe},  32'd0);
    checkOutput("f_addr1",  o_MemAddr,         32'h10);
    checkOutput("f_stall1", {31'd0, o_Stall},  32'd1);
    step();
    checkOutput("f_req2",   {31'd0, o_MemReq}, 32'd1);
    checkOutput("f_stall2", {31'd0, o_Stall},  32'd1);
    i_MemAck = 1'b1; i_MemRData = 32'h00500093;
    step();
    i_MemAck = 1'b0;
    checkOutput("f_req3",   {31'd0, o_MemReq}, 32'd0);
    checkOutput("f_instr",  o_Instr,           32'h00500093);
    checkOutput("f_oldpc",  o_OldPC,           32'h10);
    checkOutput("f_stall3", {31'd0, o_Stall},  32'd0);
    step();
    checkOutput("f_noreq",  {31'd0, o_MemReq}, 32'd0);
    applyStimulus(1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Store to Result 0x24, ack in the first WAIT cycle
    applyStimulus(1'b1, 32'h80, 32'h24, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("s_stall0", {31'd0, o_Stall}, 32'd1);
    step();
    checkOutput("s_req",   {31'd0, o_MemReq}, 32'd1);
    checkOutput("s_we",    {31'd0, o_MemWe},  32'd1);
    checkOutput("s_addr",  o_MemAddr,         32'h24);
    checkOutput("s_wdata", o_MemWData,        32'hDEADBEEF);
    i_MemAck = 1'b1; i_MemRData = 32'h0BADF00D;
    i_Result = 32'h0; i_WriteData = 32'h0;
    #1;
    checkOutput("s_addr_hold",  o_MemAddr,  32'h24);
    checkOutput("s_wdata_hold", o_MemWData, 32'hDEADBEEF);
    step();
    i_MemAck = 1'b0;
    checkOutput("s_req_done", {31'd0, o_MemReq}, 32'd0);
    checkOutput("s_we_done",  {31'd0, o_MemWe},  32'd0);
    checkOutput("s_stall3",   {31'd0, o_Stall},  32'd0);
    checkOutput("s_instr",    o_Instr,           32'h00500093);
    checkOutput("s_data",     o_Data,            32'd0);
    step();
    applyStimulus(1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Stray ack in IDLE, then load from 0x40 with five wait cycles
    i_MemAck = 1'b1; i_MemRData = 32'h00000BAD;
    #1;
    checkOutput("stray_stall", {31'd0, o_Stall}, 32'd0);
    step();
    i_MemAck = 1'b0;
    checkOutput("stray_data", o_Data,            32'd0);
    checkOutput("stray_req",  {31'd0, o_MemReq}, 32'd0);
    applyStimulus(1'b1, 32'h14, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("l_wait%0d", i), {31'd0, o_MemReq}, 32'd1);
      step();
    end
    checkOutput("l_addr", o_MemAddr, 32'h40);
    i_MemAck = 1'b1; i_MemRData = 32'h12345678;
    step();
    i_MemAck = 1'b0;
    checkOutput("l_data",  o_Data,            32'h12345678);
    checkOutput("l_req",   {31'd0, o_MemReq}, 32'd0);
    checkOutput("l_stall", {31'd0, o_Stall},  32'd0);
    step();
    checkOutput("l_no_second", {31'd0, o_MemReq}, 32'd0);
    i_MemRead = 1'b0;

    // Misaligned load at 0x42 sets the sticky fault without a request
    applyStimulus(1'b1, 32'h14, 32'h42, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("m_stall0", {31'd0, o_Stall}, 32'd1);
    step();
    checkOutput("m_req",   {31'd0, o_MemReq}, 32'd0);
    checkOutput("m_fault", {31'd0, o_Fault},  32'd1);
    checkOutput("m_stall", {31'd0, o_Stall},  32'd0);
    step();
    i_MemRead = 1'b0;
    checkOutput("m_req_idle", {31'd0, o_MemReq}, 32'd0);
    applyStimulus(1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("m_f_req",  {31'd0, o_MemReq}, 32'd1);
    checkOutput("m_f_addr", o_MemAddr,         32'h20);
    i_MemAck = 1'b1; i_MemRData = 32'h00A00113;
    step();
    i_MemAck = 1'b0;
    checkOutput("m_f_instr", o_Instr,          32'h00A00113);
    checkOutput("m_f_oldpc", o_OldPC,          32'h20);
    checkOutput("m_f_fault", {31'd0, o_Fault}, 32'd1);
    step();
    i_IRWrite = 1'b0;

    // Timeout: no ack for 16 WAIT cycles
    doReset();
    #1;
    checkOutput("t_fault_clr", {31'd0, o_Fault}, 32'd0);
    applyStimulus(1'b1, 32'h0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t_wait%0d", i), {31'd0, o_MemReq}, 32'd1);
      step();
    end
    checkOutput("t_req",   {31'd0, o_MemReq}, 32'd0);
    checkOutput("t_fault", {31'd0, o_Fault},  32'd1);
    checkOutput("t_stall", {31'd0, o_Stall},  32'd0);
    checkOutput("t_data",  o_Data,            32'd0);
    step();
    i_MemRead = 1'b0;

    // Ack exactly in the 16th WAIT cycle completes normally
    doReset();
    applyStimulus(1'b1, 32'h0, 32'h84, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 15; i++) step();
    checkOutput("a16_req", {31'd0, o_MemReq}, 32'd1);
    i_MemAck = 1'b1; i_MemRData = 32'hCAFEF00D;
    step();
    i_MemAck = 1'b0;
    checkOutput("a16_data",  o_Data,            32'hCAFEF00D);
    checkOutput("a16_fault", {31'd0, o_Fault},  32'd0);
    checkOutput("a16_req2",  {31'd0, o_MemReq}, 32'd0);
    step();
    i_MemRead = 1'b0;

    // Reset in WAIT (with a coinciding ack), then simultaneous IRWrite+MemWrite
    applyStimulus(1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("r_req_wait", {31'd0, o_MemReq}, 32'd1);
    i_Reset = 1'b1; i_MemAck = 1'b1; i_MemRData = 32'h11111111;
    step();
    i_Reset = 1'b0; i_MemAck = 1'b0; i_IRWrite = 1'b0;
    checkOutput("r_req",   {31'd0, o_MemReq}, 32'd0);
    checkOutput("r_addr",  o_MemAddr,         32'd0);
    checkOutput("r_data",  o_Data,            32'd0);
    checkOutput("r_instr", o_Instr,           32'd0);
    applyStimulus(1'b0, 32'h44, 32'h0, 32'h55, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("r_f_req",  {31'd0, o_MemReq}, 32'd1);
    checkOutput("r_f_we",   {31'd0, o_MemWe},  32'd0);
    checkOutput("r_f_addr", o_MemAddr,         32'h44);
    i_MemAck = 1'b1; i_MemRData = 32'h00000013;
    step();
    i_MemAck = 1'b0;
    checkOutput("r_f_instr", o_Instr, 32'h00000013);
    checkOutput("r_f_oldpc", o_OldPC, 32'h44);
    checkOutput("r_f_data",  o_Data,  32'd0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multi-cycle control FSM.
- Turns the FSM's single-cycle memory strobes (IRWrite, MemWrite, MemRead) into a req/ack handshake with a variable-latency word memory.
- Holds the Instruction, OldPC and Data registers, and raises o_Stall so the controller keeps its current state until the access completes.
- Flags misaligned addresses and memory timeouts as a sticky fault.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (word accesses only).
- TIMEOUT, 16, maximum WAIT cycles without ack before abort (minimum 2).

Ports:
- i_Clk  in  1  clock.
- i_Reset  in  1  reset; synchronous, active-high.
- i_AdrSrc  in  1  address select: 0 = i_PC, 1 = i_Result.
- i_PC  in  ADDR_W  current PC.
- i_Result  in  ADDR_W  ALU/result bus (data address).
- i_WriteData  in  DATA_W  store data.
- i_IRWrite  in  1  fetch strobe (FETCH state).
- i_MemWrite  in  1  store strobe (MEMWRITE state).
- i_MemRead  in  1  load strobe (MEMREAD state).
- o_MemReq  out  1  memory request, held until ack.
- o_MemWe  out  1  write enable, qualified by o_MemReq.
- o_MemAddr  out  ADDR_W  registered request address.
- o_MemWData  out  DATA_W  registered store data.
- i_MemAck  in  1  one-cycle completion pulse from memory.
- i_MemRData  in  DATA_W  read data, valid with i_MemAck.
- o_Instr  out  DATA_W  instruction register.
- o_OldPC  out  ADDR_W  PC of the fetched instruction.
- o_Data  out  DATA_W  load data register.
- o_Stall  out  1  controller hold.
- o_Fault  out  1  sticky fault flag.

Behaviour:
- States: IDLE, WAIT, DONE.
- Reset (sampled at a clock edge): state = IDLE; all outputs and registers = 0, o_Fault included.
  - Reset during WAIT drops o_MemReq on the next cycle; the aborted access loads nothing.
- Strobe priority when several are asserted: IRWrite > MemWrite > MemRead.
- Address: A = i_AdrSrc ? i_Result : i_PC.
- IDLE, any strobe asserted:
  - Capture A into o_MemAddr and i_WriteData into o_MemWData.
  - o_MemWe = 1 only for MemWrite; record the access kind.
  - For a fetch, capture i_PC into a pending-OldPC register.
  - o_Stall = 1 combinationally in this same cycle.
  - If A[1:0] != 0: set o_Fault, issue no request, go to DONE.
  - Otherwise set o_MemReq = 1 (registered) and go to WAIT.
- IDLE, no strobe: o_Stall = 0.
- WAIT:
  - o_Stall = 1. o_MemReq, o_MemWe, o_MemAddr and o_MemWData stay stable.
  - i_MemAck is sampled only here; an ack arriving in IDLE or DONE is ignored.
  - Wait counter starts at 0 on entry to WAIT and increments every cycle without ack.
  - On i_MemAck, per access kind:
    - Fetch: o_Instr <= i_MemRData and o_OldPC <= pending-OldPC.
    - Load: o_Data <= i_MemRData.
    - Store: no register load.
  - On i_MemAck: o_MemReq and o_MemWe go to 0; go to DONE.
  - If the counter reaches TIMEOUT-1 without ack: set o_Fault, drop o_MemReq, load nothing, go to DONE.
  - An ack arriving on that same cycle takes precedence over the timeout.
- DONE:
  - Exactly one cycle; o_Stall = 0, so the controller advances at the end of this cycle.
  - Strobes are ignored here (they still belong to the finishing FSM state). Return to IDLE.
- Latency: strobe in cycle 0 gives o_MemReq high from cycle 1. Ack in cycle k loads the registers at the end of cycle k. DONE is cycle k+1 (stall low). Zero-wait memory (ack in cycle 1) therefore costs 3 cycles per access.
- Ack coinciding with reset: reset wins.
- o_Fault stays high until reset and does not block later accesses.

Test Plan:
- Fetch, PC = 0x10, ack 2 cycles after req, rdata 0x00500093 -> o_MemReq high for 2 cycles, o_MemWe = 0, o_MemAddr = 0x10, then o_Instr = 0x00500093 and o_OldPC = 0x10. o_Stall is high from the strobe cycle through the ack cycle and low in DONE.
- Store, i_AdrSrc = 1, Result = 0x24, WriteData = 0xDEADBEEF, ack in 1st WAIT cycle -> o_MemWe = 1, address and data stable until ack, o_Instr and o_Data unchanged, 3-cycle access.
- Load, addr 0x40, rdata 0x12345678 after 5 waits; a stray ack injected in IDLE beforehand -> stray ack ignored, o_Data = 0x12345678, strobe still high in DONE does not start a second request.
- Misaligned load at 0x42 -> no o_MemReq ever, o_Fault = 1 sticky; next aligned fetch completes normally with o_Fault still 1.
- No ack for 16 WAIT cycles -> o_MemReq drops, o_Fault = 1, DONE follows.
- Separately, ack on cycle 16 exactly -> normal completion, no fault.
- Reset asserted in WAIT, then IRWrite and MemWrite asserted together -> all outputs 0 after reset; the simultaneous strobes perform a fetch (o_MemWe = 0).
